// File: rtl/psum_binarize_packer.sv
// Sums NUM_CHANNELS psum beats per pixel with saturation, thresholds each pixel
// into one activation bit and packs PACK_WIDTH bits (LSB = oldest) per output word.
module psum_binarize_packer #(
  parameter int PSUM_DATA_WIDTH = 12,
  parameter int ACC_WIDTH       = 20,
  parameter int NUM_CHANNELS    = 4,
  parameter int PACK_WIDTH      = 8,
  parameter logic signed [ACC_WIDTH-1:0] THRESHOLD = '0
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [PSUM_DATA_WIDTH-1:0]         in_psum,
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [PACK_WIDTH-1:0]              out_bits,
  output logic [$clog2(PACK_WIDTH+1)-1:0]    out_count,
  output logic                               out_last
);
  localparam int CNT_W = $clog2(PACK_WIDTH+1);
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int BIT_W = $clog2(PACK_WIDTH);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic                  vld;
    logic [PACK_WIDTH-1:0] bits;
    logic [CNT_W-1:0]      count;
    logic                  last;
  } out_word_t;

  out_word_t                   ow;
  logic signed [ACC_WIDTH-1:0] acc;
  logic [CH_W-1:0]             ch_cnt;
  logic [BIT_W-1:0]            bit_cnt;
  logic [PACK_WIDTH-1:0]       pack_reg;

  logic                        in_acc, pixel_beat, word_close, act_bit;
  logic [ACC_WIDTH:0]          sum_ext;
  logic signed [ACC_WIDTH-1:0] sum_sat;
  logic [PACK_WIDTH-1:0]       new_word;

  assign in_ready   = !ow.vld | out_ready;
  assign in_acc     = in_valid & in_ready;
  assign pixel_beat = (ch_cnt == CH_W'(NUM_CHANNELS-1));
  assign word_close = in_acc & pixel_beat & ((bit_cnt == BIT_W'(PACK_WIDTH-1)) | in_last);

  // One extra bit of headroom: overflow shows as a mismatch of the top two bits.
  assign sum_ext = {acc[ACC_WIDTH-1], acc}
                 + {{(ACC_WIDTH+1-PSUM_DATA_WIDTH){in_psum[PSUM_DATA_WIDTH-1]}}, in_psum};

  always_comb begin
    sum_sat = sum_ext[ACC_WIDTH-1:0];
    if (sum_ext[ACC_WIDTH] != sum_ext[ACC_WIDTH-1])
      sum_sat = sum_ext[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
  end

  assign act_bit  = (sum_sat >= THRESHOLD);
  assign new_word = pack_reg | (PACK_WIDTH'(act_bit) << bit_cnt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      ch_cnt   <= '0;
      bit_cnt  <= '0;
      pack_reg <= '0;
    end else if (in_acc) begin
      if (!pixel_beat) begin
        acc    <= sum_sat;
        ch_cnt <= ch_cnt + CH_W'(1);
      end else begin
        acc    <= '0;
        ch_cnt <= '0;
        if (word_close) begin
          pack_reg <= '0;
          bit_cnt  <= '0;
        end else begin
          pack_reg <= new_word;
          bit_cnt  <= bit_cnt + BIT_W'(1);
        end
      end
    end
  end

  // A closing word overrides the drop of out_valid so back-to-back words have no bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ow <= '0;
    end else if (word_close) begin
      ow.vld   <= 1'b1;
      ow.bits  <= new_word;
      ow.count <= CNT_W'(bit_cnt) + CNT_W'(1);
      ow.last  <= in_last;
    end else if (ow.vld && out_ready) begin
      ow.vld <= 1'b0;
    end
  end

  assign out_valid = ow.vld;
  assign out_bits  = ow.bits;
  assign out_count = ow.count;
  assign out_last  = ow.last;
endmodule

// File: tb/tb_psum_binarize_packer.sv
// Directed bench: three configurations (default, 13-bit accumulator, single channel)
// share one stimulus port selected by sel; output words are captured into a queue.
module tb_psum_binarize_packer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_last, out_ready;
  logic [11:0] in_psum;
  logic [1:0]  sel;

  logic [2:0]  iv_d, ov, ir, ol;
  logic [7:0]  ob [3];
  logic [3:0]  oc [3];

  logic        in_ready, out_valid, out_last;
  logic [7:0]  out_bits;
  logic [3:0]  out_count;

  int nvec = 0;
  int nerr = 0;
  logic [12:0] q [$];

  always #5 clk = ~clk;

  assign iv_d[0]   = in_valid && (sel == 2'd0);
  assign iv_d[1]   = in_valid && (sel == 2'd1);
  assign iv_d[2]   = in_valid && (sel == 2'd2);
  assign in_ready  = ir[sel];
  assign out_valid = ov[sel];
  assign out_last  = ol[sel];
  assign out_bits  = ob[sel];
  assign out_count = oc[sel];

  psum_binarize_packer u_dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv_d[0]), .in_ready(ir[0]), .in_psum(in_psum),
    .in_last(in_last), .out_valid(ov[0]), .out_ready(out_ready), .out_bits(ob[0]),
    .out_count(oc[0]), .out_last(ol[0]));

  psum_binarize_packer #(.ACC_WIDTH(13)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv_d[1]), .in_ready(ir[1]), .in_psum(in_psum),
    .in_last(in_last), .out_valid(ov[1]), .out_ready(out_ready), .out_bits(ob[1]),
    .out_count(oc[1]), .out_last(ol[1]));

  psum_binarize_packer #(.NUM_CHANNELS(1)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv_d[2]), .in_ready(ir[2]), .in_psum(in_psum),
    .in_last(in_last), .out_valid(ov[2]), .out_ready(out_ready), .out_bits(ob[2]),
    .out_count(oc[2]), .out_last(ol[2]));

  always @(negedge clk)
    if (reset_n && out_valid && out_ready) q.push_back({out_bits, out_count, out_last});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input int p, input logic l);
    int n = 0;
    in_valid = 1'b1; in_psum = p[11:0]; in_last = l;
    @(negedge clk);
    while (!in_ready && n < 50) begin n++; @(negedge clk); end
    if (!in_ready) begin
      chk("send_timeout", 32'(in_ready), 32'd1);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic pix(input int s, input logic l);
    send(s - 6, 1'b0); send(3, 1'b0); send(2, 1'b0); send(1, l);
  endtask

  task automatic expect_word(input string tag, input logic [7:0] b, input logic [3:0] c,
                             input logic l);
    int n = 0;
    logic [12:0] w;
    while (q.size() == 0 && n < 50) begin n++; @(posedge clk); #1; end
    if (q.size() == 0) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      w = q.pop_front();
      chk({tag, "_bits"}, 32'(w[12:5]), 32'(b));
      chk({tag, "_cnt"},  32'(w[4:1]),  32'(c));
      chk({tag, "_last"}, 32'(w[0]),    32'(l));
    end
  endtask

  initial begin
    sel = 2'd0; in_valid = 1'b0; in_last = 1'b0; in_psum = '0; out_ready = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_ovld",  32'(out_valid), 32'd0);
    chk("rst_bits",  32'(out_bits),  32'd0);
    chk("rst_cnt",   32'(out_count), 32'd0);
    chk("rst_last",  32'(out_last),  32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_irdy",  32'(in_ready),  32'd1);

    // all-ones word, one cycle after the 32nd beat
    for (int i = 0; i < 8; i++) begin
      send(10, 1'b0); send(-3, 1'b0); send(-2, 1'b0);
      if (i == 7) chk("t1_early", 32'(out_valid), 32'd0);
      send(-4, 1'b0);
    end
    chk("t1_ovld", 32'(out_valid), 32'd1);
    chk("t1_bits", 32'(out_bits),  32'hFF);
    expect_word("t1", 8'hFF, 4'd8, 1'b0);

    for (int i = 0; i < 8; i++) pix((i % 2) ? -5 : 5, 1'b0);
    expect_word("t2_alt", 8'h55, 4'd8, 1'b0);
    pix(0, 1'b0); pix(-1, 1'b0); pix(-1, 1'b0); pix(0, 1'b0);
    pix(-7, 1'b0); pix(0, 1'b0); pix(-1, 1'b0); pix(0, 1'b0);
    expect_word("t2_zero", 8'hA9, 4'd8, 1'b0);

    // partial word flush, then in_last on a non-pixel beat must be ignored
    pix(1, 1'b0); pix(-1, 1'b0); pix(1, 1'b1);
    expect_word("t3_flush", 8'h05, 4'd3, 1'b1);
    send(1, 1'b1); send(0, 1'b0); send(0, 1'b0); send(0, 1'b0);
    for (int i = 0; i < 7; i++) pix(-1, 1'b0);
    expect_word("t3_next", 8'h01, 4'd8, 1'b0);

    // saturation with a 13-bit accumulator
    sel = 2'd1;
    repeat (4) send(2047, 1'b0);
    repeat (3) send(-2048, 1'b0);
    send(-2048, 1'b1);
    expect_word("t5_sat", 8'h01, 4'd2, 1'b1);

    // backpressure and back-to-back word load, single channel
    sel = 2'd2; out_ready = 1'b0;
    send(1, 1'b0); send(1, 1'b0); send(-1, 1'b0); send(-1, 1'b0);
    send(1, 1'b0); send(-1, 1'b0); send(1, 1'b0); send(1, 1'b0);
    chk("t4_hold_vld", 32'(out_valid), 32'd1);
    in_valid = 1'b1; in_psum = 12'd3; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_stall_rdy",  32'(in_ready), 32'd0);
      chk("t4_stall_bits", 32'(out_bits), 32'hD3);
      chk("t4_stall_cnt",  32'(out_count), 32'd8);
    end
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("t4_b2b_vld",  32'(out_valid), 32'd1);
    chk("t4_b2b_bits", 32'(out_bits),  32'h01);
    chk("t4_b2b_cnt",  32'(out_count), 32'd1);
    chk("t4_b2b_last", 32'(out_last),  32'd1);
    expect_word("t4_b2b", 8'h01, 4'd1, 1'b1);

    // reset discards a held word
    sel = 2'd0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) pix(1, 1'b0);
    chk("t6_held", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6a_ovld", 32'(out_valid), 32'd0);
    chk("t6a_bits", 32'(out_bits),  32'd0);
    chk("t6a_cnt",  32'(out_count), 32'd0);
    chk("t6a_irdy", 32'(in_ready),  32'd1);
    @(negedge clk) reset_n = 1'b1;
    out_ready = 1'b1;

    // reset mid-pixel and mid-word discards acc, counters and packed bits
    pix(1, 1'b0); pix(1, 1'b0); pix(1, 1'b0);
    send(-100, 1'b0); send(-100, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("t6b_ovld", 32'(out_valid), 32'd0);
    chk("t6b_last", 32'(out_last),  32'd0);
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(10, 1'b0); send(-3, 1'b0); send(-2, 1'b0); send(-4, 1'b0);
    end
    expect_word("t6_clean", 8'hFF, 4'd8, 1'b0);

    repeat (3) @(posedge clk); #1;
    chk("q_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
